// File: rtl/moving_sum_pkg.sv
// Shared helpers for the moving-sum block: width derivation and parameter checks.
package moving_sum_pkg;

    // Width of a sum of 'win' unsigned samples of 'dw' bits each.
    function automatic int sum_width(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

    // Width of a counter that must represent every value from 0 to 'win'.
    function automatic int fill_width(input int win);
        return $clog2(win) + 32'sd1;
    endfunction

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/win_fill_cnt.sv
// Saturating window-fill counter. Counts enabled samples since reset or clear,
// stops at WIN, and flags when the window holds a complete set of samples.
module win_fill_cnt
    import moving_sum_pkg::*;
#(
    parameter  int WIN = 32,
    localparam int FW  = fill_width(WIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [FW-1:0] fill_next,
    output logic          full
);

    localparam logic [FW-1:0] WIN_C  = FW'(WIN);
    localparam logic [FW-1:0] ONE_C  = FW'(32'd1);
    localparam logic [FW-1:0] ZERO_C = {FW{1'b0}};

    logic [FW-1:0] fill_r;
    logic [FW-1:0] fill_next_s;
    logic          full_r;

    // Next fill count: a clear restarts the window (counting a coincident sample), otherwise saturate at WIN.
    always_comb begin
        fill_next_s = fill_r;
        if (rst) begin
            fill_next_s = ZERO_C;
        end else if (clr) begin
            if (en) begin
                fill_next_s = ONE_C;
            end else begin
                fill_next_s = ZERO_C;
            end
        end else if (en && (fill_r < WIN_C)) begin
            fill_next_s = fill_r + ONE_C;
        end else begin
            fill_next_s = fill_r;
        end
    end

    // Fill count and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r <= ZERO_C;
            full_r <= 1'b0;
        end else begin
            fill_r <= fill_next_s;
            full_r <= (fill_next_s == WIN_C);
        end
    end

    assign fill_next = fill_next_s;
    assign full      = full_r;

endmodule

// File: rtl/moving_sum_avg.sv
// Running sum and average over the last WIN enabled samples. The caller supplies
// the live sample and the same stream delayed by WIN enabled samples; the delayed
// sample is masked until the window is full because the delay storage is never reset.
module moving_sum_avg
    import moving_sum_pkg::*;
#(
    parameter  int DW  = 8,
    parameter  int WIN = 32,
    localparam int SW  = sum_width(DW, WIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] din_dly,
    output logic [SW-1:0] sum,
    output logic [DW-1:0] avg,
    output logic          out_vld,
    output logic          full
);

    localparam int            LOG2W = $clog2(WIN);
    localparam int            FW    = fill_width(WIN);
    localparam logic [FW-1:0] WIN_C = FW'(WIN);

    if (!is_pow2(WIN) || (WIN < 2)) begin : g_bad_win
        $error("moving_sum_avg: WIN must be a power of two and at least 2");
    end
    if (DW < 1) begin : g_bad_dw
        $error("moving_sum_avg: DW must be at least 1");
    end

    logic [FW-1:0] fill_next_s;
    logic          full_s;
    logic [DW-1:0] sub_s;
    logic [SW-1:0] sum_next_s;
    logic [DW-1:0] avg_next_s;
    logic          vld_next_s;
    logic [SW-1:0] sum_r;
    logic [DW-1:0] avg_r;
    logic          out_vld_r;

    win_fill_cnt #(
        .WIN (WIN)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (en),
        .fill_next (fill_next_s),
        .full      (full_s)
    );

    // Only subtract the delayed sample once the window has been full before this edge.
    always_comb begin
        sub_s = {DW{1'b0}};
        if (full_s) begin
            sub_s = din_dly;
        end else begin
            sub_s = {DW{1'b0}};
        end
    end

    // Next sum: clear restarts the window, enabled sample adds din and retires the oldest one.
    always_comb begin
        sum_next_s = sum_r;
        if (clr) begin
            if (en) begin
                sum_next_s = SW'(din);
            end else begin
                sum_next_s = {SW{1'b0}};
            end
        end else if (en) begin
            sum_next_s = SW'({1'b0, sum_r} + (SW+1)'(din) - (SW+1)'(sub_s));
        end else begin
            sum_next_s = sum_r;
        end
    end

    // Average is the truncating divide of the new sum; valid pulses when a full window is updated.
    always_comb begin
        avg_next_s = sum_next_s[SW-1:LOG2W];
        vld_next_s = 1'b0;
        if (en && !clr && (fill_next_s == WIN_C)) begin
            vld_next_s = 1'b1;
        end else begin
            vld_next_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r     <= {SW{1'b0}};
            avg_r     <= {DW{1'b0}};
            out_vld_r <= 1'b0;
        end else begin
            sum_r     <= sum_next_s;
            avg_r     <= avg_next_s;
            out_vld_r <= vld_next_s;
        end
    end

    assign sum     = sum_r;
    assign avg     = avg_r;
    assign out_vld = out_vld_r;
    assign full    = full_s;

endmodule

// File: tb/tb_moving_sum_avg.sv
// Directed self-checking bench for moving_sum_avg (DW=8, WIN=4). A window model
// keeps the samples accepted since the last reset/clear; expectations are pushed
// to a scoreboard when inputs are driven and checked one edge later.
module tb_moving_sum_avg;

    localparam int DW  = 8;
    localparam int WIN = 4;
    localparam int SW  = 10;

    typedef struct {
        logic [SW-1:0] sum;
        logic [DW-1:0] avg;
        logic          vld;
        logic          full;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = 8'h00;
    logic [DW-1:0] din_dly = 8'h00;
    logic [SW-1:0] sum;
    logic [DW-1:0] avg;
    logic          out_vld;
    logic          full;

    int total = 0;
    int bad   = 0;

    exp_t       sb_q[$];
    logic [7:0] win_q[$];

    moving_sum_avg #(
        .DW  (DW),
        .WIN (WIN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .din     (din),
        .din_dly (din_dly),
        .sum     (sum),
        .avg     (avg),
        .out_vld (out_vld),
        .full    (full)
    );

    always #5 clk = ~clk;

    // Pop one expectation and compare it against the outputs after the edge.
    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: got empty queue want an entry");
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (sum === e.sum) else begin
                bad++;
                $error("FAIL sum: got %0d want %0d", sum, e.sum);
            end
            total++;
            assert (avg === e.avg) else begin
                bad++;
                $error("FAIL avg: got %0d want %0d", avg, e.avg);
            end
            total++;
            assert (out_vld === e.vld) else begin
                bad++;
                $error("FAIL out_vld: got %0b want %0b", out_vld, e.vld);
            end
            total++;
            assert (full === e.full) else begin
                bad++;
                $error("FAIL full: got %0b want %0b", full, e.full);
            end
        end
    endtask

    // Drive one cycle, update the window model, push the expectation, then check after the edge.
    task automatic do_step(input logic r, input logic e, input logic c,
                           input logic [7:0] d, input logic [7:0] dd);
        exp_t x;
        int   s;
        rst     = r;
        en      = e;
        clr     = c;
        din     = d;
        din_dly = dd;
        x.vld   = 1'b0;
        if (r || (c && !e)) begin
            win_q.delete();
        end else if (c && e) begin
            win_q.delete();
            win_q.push_back(d);
        end else if (e) begin
            win_q.push_back(d);
            if (win_q.size() > WIN) begin
                void'(win_q.pop_front());
            end
            x.vld = (win_q.size() == WIN);
        end
        s = 0;
        foreach (win_q[i]) s += int'(win_q[i]);
        x.sum  = SW'(s);
        x.avg  = DW'(s / WIN);
        x.full = (win_q.size() == WIN);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Enabled sample with a correct delayed sample once full, garbage before that.
    task automatic auto_step(input logic [7:0] d);
        logic [7:0] dd;
        dd = (win_q.size() == WIN) ? win_q[0] : 8'hAA;
        do_step(1'b0, 1'b1, 1'b0, d, dd);
    endtask

    initial begin
        // Reset held with en asserted and max data: outputs must stay zero.
        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);

        // Fill 1,2,3,4 with garbage delayed samples.
        auto_step(8'd1);
        auto_step(8'd2);
        auto_step(8'd3);
        auto_step(8'd4);

        // Steady state.
        auto_step(8'd5);
        auto_step(8'd6);

        // Gap of 5 idle cycles with junk on the data inputs, then resume.
        for (int i = 0; i < 5; i++) do_step(1'b0, 1'b0, 1'b0, 8'h33, 8'hCC);
        auto_step(8'd7);

        // Maximum values.
        for (int i = 0; i < 8; i++) auto_step(8'hFF);

        // Clear with a coincident sample, refill with garbage delayed samples.
        do_step(1'b0, 1'b1, 1'b1, 8'd7, 8'h12);
        for (int i = 0; i < 3; i++) do_step(1'b0, 1'b1, 1'b0, 8'd7, 8'h55);

        // Clear without a sample.
        do_step(1'b0, 1'b0, 1'b1, 8'd9, 8'h99);

        // Random stretch with occasional idle cycles.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_step(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            end else begin
                auto_step(8'($urandom));
            end
        end

        // Reset mid-operation behaves like a clear; first sample afterwards accepted normally.
        do_step(1'b1, 1'b1, 1'b1, 8'h40, 8'h40);
        auto_step(8'd11);
        auto_step(8'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
